// File: rtl/avmm_paged_window_mem.sv
// Avalon-MM paged window memory: BAR0 CSRs (ID, page count, error count, page select)
// and a BAR2 data window mapping one page of an on-chip RAM, read latency 2.
module avmm_paged_window_mem #(
   parameter int          DW         = 64,
   parameter int          WIN_WORDS  = 16,
   parameter int          PAGE_COUNT = 4,
   parameter logic [31:0] ID_VALUE   = 32'hB16A0001,
   localparam int         OW         = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1
) (
   input  logic            clk_in,
   input  logic            rst,
   input  logic [1:0]      csr_address,
   input  logic            csr_read,
   input  logic            csr_write,
   input  logic [31:0]     csr_writedata,
   output logic [31:0]     csr_readdata,
   input  logic [OW-1:0]   win_address,
   input  logic            win_read,
   input  logic            win_write,
   input  logic [DW/8-1:0] win_byteenable,
   input  logic [DW-1:0]   win_writedata,
   output logic [DW-1:0]   win_readdata,
   output logic            win_readdatavalid,
   output logic            win_waitrequest
);

   localparam int              DEPTH      = PAGE_COUNT * WIN_WORDS;
   localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              NB         = DW / 8;
   localparam logic [DW-1:0]   OOR_DATA   = {DW/32{32'hDEADBEEF}};
   localparam logic [16:0]     PAGE_LIMIT = 17'(PAGE_COUNT);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ram_q;

   logic [15:0]   page_q;
   logic [31:0]   err_cnt_q;
   logic          wait_q;
   logic          rd1_valid_q;
   logic          rd1_oor_q;

   logic          cmd_acc;
   logic          wr_acc;
   logic          rd_acc;
   logic          page_oor;
   logic [AW-1:0] ram_idx;
   logic          unused_wdata_hi;

   assign win_waitrequest = wait_q;
   assign unused_wdata_hi = ^csr_writedata[31:16];

   // A command sees the page register as it stood before any same-cycle CSR write.
   assign cmd_acc  = (win_read | win_write) & ~wait_q & ~rst;
   assign wr_acc   = cmd_acc & win_write;
   assign rd_acc   = cmd_acc & ~win_write;
   assign page_oor = {1'b0, page_q} >= PAGE_LIMIT;
   assign ram_idx  = AW'(page_q) * AW'(WIN_WORDS) + AW'(win_address);

   // NOTE: the RAM array and its output register carry no reset so they map onto
   // block RAM; contents survive rst by design.
   always_ff @(posedge clk_in) begin
      if (wr_acc && !page_oor) begin
         for (int b = 0; b < NB; b++) begin
            if (win_byteenable[b]) begin
               mem[ram_idx][b*8 +: 8] <= win_writedata[b*8 +: 8];
            end
         end
      end
      if (rd_acc && !page_oor) begin
         ram_q <= mem[ram_idx];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         wait_q            <= 1'b1;
         page_q            <= '0;
         err_cnt_q         <= '0;
         csr_readdata      <= '0;
         rd1_valid_q       <= 1'b0;
         rd1_oor_q         <= 1'b0;
         win_readdata      <= '0;
         win_readdatavalid <= 1'b0;
      end else begin
         wait_q <= 1'b0;

         if (csr_write && csr_address == 2'd3) begin
            page_q <= csr_writedata[15:0];
         end

         // A host clear wins over a same-cycle out-of-range increment.
         if (csr_write && csr_address == 2'd2) begin
            err_cnt_q <= '0;
         end else if (cmd_acc && page_oor && err_cnt_q != 32'hFFFF_FFFF) begin
            err_cnt_q <= err_cnt_q + 32'd1;
         end

         if (csr_read) begin
            case (csr_address)
               2'd0:    csr_readdata <= ID_VALUE;
               2'd1:    csr_readdata <= 32'(PAGE_COUNT);
               2'd2:    csr_readdata <= err_cnt_q;
               default: csr_readdata <= {16'h0000, page_q};
            endcase
         end

         rd1_valid_q       <= rd_acc;
         rd1_oor_q         <= page_oor;
         win_readdatavalid <= rd1_valid_q;
         if (rd1_valid_q) begin
            win_readdata <= rd1_oor_q ? OOR_DATA : ram_q;
         end
      end
   end

endmodule

// File: tb/tb_avmm_paged_window_mem.sv
// Directed bench for avmm_paged_window_mem: inputs change and outputs are sampled on
// the falling edge; every expected value is written out by hand or by the pat() formula.
module tb_avmm_paged_window_mem;

   logic        clk_in = 1'b0;
   logic        rst;
   logic [1:0]  csr_address;
   logic        csr_read;
   logic        csr_write;
   logic [31:0] csr_writedata;
   logic [31:0] csr_readdata;
   logic [3:0]  win_address;
   logic        win_read;
   logic        win_write;
   logic [7:0]  win_byteenable;
   logic [63:0] win_writedata;
   logic [63:0] win_readdata;
   logic        win_readdatavalid;
   logic        win_waitrequest;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk_in = ~clk_in;

   avmm_paged_window_mem dut (
      .clk_in            (clk_in),
      .rst               (rst),
      .csr_address       (csr_address),
      .csr_read          (csr_read),
      .csr_write         (csr_write),
      .csr_writedata     (csr_writedata),
      .csr_readdata      (csr_readdata),
      .win_address       (win_address),
      .win_read          (win_read),
      .win_write         (win_write),
      .win_byteenable    (win_byteenable),
      .win_writedata     (win_writedata),
      .win_readdata      (win_readdata),
      .win_readdatavalid (win_readdatavalid),
      .win_waitrequest   (win_waitrequest)
   );

   function automatic logic [63:0] pat(input int p, input int o);
      return {8'(p), 8'(o), 16'hA55A, 8'(p), 8'(o), 16'h5AA5};
   endfunction

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk_in);
   endtask

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      csr_write = 1'b1; csr_address = a; csr_writedata = d;
      tick();
      csr_write = 1'b0;
   endtask

   task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      csr_read = 1'b1; csr_address = a;
      tick();
      csr_read = 1'b0;
      check(tag, 64'(csr_readdata), 64'(exp));
   endtask

   task automatic wr(input logic [3:0] o, input logic [7:0] be, input logic [63:0] d);
      win_write = 1'b1; win_address = o; win_byteenable = be; win_writedata = d;
      tick();
      win_write = 1'b0;
   endtask

   // Read, then confirm no valid after one cycle and valid with data after two.
   task automatic rd_check(input logic [3:0] o, input logic [63:0] exp, input string tag);
      win_read = 1'b1; win_address = o;
      tick();
      win_read = 1'b0;
      check({tag, "_lat1"}, 64'(win_readdatavalid), 64'd0);
      tick();
      check({tag, "_valid"}, 64'(win_readdatavalid), 64'd1);
      check({tag, "_data"}, win_readdata, exp);
   endtask

   initial begin
      rst = 1'b1; csr_address = 2'd0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
      win_address = '0; win_read = 1'b0; win_write = 1'b0; win_byteenable = '0; win_writedata = '0;
      repeat (3) tick();
      check("rst_csr_readdata", 64'(csr_readdata), 64'd0);
      check("rst_win_readdata", win_readdata, 64'd0);
      check("rst_valid", 64'(win_readdatavalid), 64'd0);
      check("rst_waitrequest", 64'(win_waitrequest), 64'd1);
      rst = 1'b0;
      check("wait_after_rst_low", 64'(win_waitrequest), 64'd1);
      tick();
      check("wait_dropped", 64'(win_waitrequest), 64'd0);

      // ID / configuration
      csr_rd(2'd0, 32'hB16A0001, "csr_id");
      csr_rd(2'd1, 32'h0000_0004, "csr_page_count");
      csr_rd(2'd3, 32'h0000_0000, "csr_page_rst");
      csr_rd(2'd2, 32'h0000_0000, "csr_err_rst");
      csr_wr(2'd0, 32'h0000_0000);
      csr_wr(2'd1, 32'h0000_0009);
      csr_rd(2'd0, 32'hB16A0001, "csr_id_ro");
      csr_rd(2'd1, 32'h0000_0004, "csr_page_count_ro");

      // Fill every page and read it all back
      for (int p = 0; p < 4; p++) begin
         csr_wr(2'd3, 32'(p));
         for (int o = 0; o < 16; o++) wr(4'(o), 8'hFF, pat(p, o));
      end
      for (int p = 0; p < 4; p++) begin
         csr_wr(2'd3, 32'(p));
         csr_rd(2'd3, 32'(p), $sformatf("page_rb_%0d", p));
         for (int o = 0; o < 16; o++) rd_check(4'(o), pat(p, o), $sformatf("fill_p%0d_o%0d", p, o));
      end

      // Byte enables, zero-byteenable no-op, write-first read-after-write
      csr_wr(2'd3, 32'd1);
      wr(4'd3, 8'hFF, 64'h1122334455667788);
      wr(4'd3, 8'h0F, 64'hFFFFFFFFFFFFFFFF);
      rd_check(4'd3, 64'h11223344FFFFFFFF, "be_low_half");
      wr(4'd3, 8'h00, 64'h0000000000000000);
      rd_check(4'd3, 64'h11223344FFFFFFFF, "be_zero_noop");
      wr(4'd4, 8'hFF, 64'hCAFEF00D12345678);
      rd_check(4'd4, 64'hCAFEF00D12345678, "raw_back_to_back");

      // Read and write together: the write wins and no data comes back
      win_read = 1'b1; win_write = 1'b1; win_address = 4'd5;
      win_byteenable = 8'hFF; win_writedata = 64'h0BADC0DE600DF00D;
      tick();
      win_read = 1'b0; win_write = 1'b0;
      check("rdwr_no_valid1", 64'(win_readdatavalid), 64'd0);
      tick();
      check("rdwr_no_valid2", 64'(win_readdatavalid), 64'd0);
      rd_check(4'd5, 64'h0BADC0DE600DF00D, "rdwr_write_took");

      // CSR read and write together return the old PAGE
      csr_read = 1'b1; csr_write = 1'b1; csr_address = 2'd3; csr_writedata = 32'd3;
      tick();
      csr_read = 1'b0; csr_write = 1'b0;
      check("csr_rdwr_old", 64'(csr_readdata), 64'd1);
      csr_rd(2'd3, 32'd3, "csr_rdwr_new");

      // Page race: second read uses old page even though PAGE changes that cycle
      csr_wr(2'd3, 32'd0);
      win_read = 1'b1; win_address = 4'd0;
      tick();
      csr_write = 1'b1; csr_address = 2'd3; csr_writedata = 32'd2;
      check("race_lat1", 64'(win_readdatavalid), 64'd0);
      tick();
      csr_write = 1'b0;
      check("race_r1_valid", 64'(win_readdatavalid), 64'd1);
      check("race_r1_data", win_readdata, pat(0, 0));
      tick();
      win_read = 1'b0;
      check("race_r2_valid", 64'(win_readdatavalid), 64'd1);
      check("race_r2_data", win_readdata, pat(0, 0));
      tick();
      check("race_r3_valid", 64'(win_readdatavalid), 64'd1);
      check("race_r3_data", win_readdata, pat(2, 0));
      tick();
      check("race_idle", 64'(win_readdatavalid), 64'd0);

      // Out-of-range page
      csr_wr(2'd3, 32'd5);
      wr(4'd0, 8'hFF, 64'h0123456789ABCDEF);
      rd_check(4'd0, 64'hDEADBEEFDEADBEEF, "oor_read");
      csr_rd(2'd2, 32'd2, "oor_err_cnt");
      csr_wr(2'd3, 32'd1);
      rd_check(4'd0, pat(1, 0), "oor_p1_o0_intact");
      rd_check(4'd3, 64'h11223344FFFFFFFF, "oor_p1_o3_intact");
      csr_wr(2'd2, 32'h0000_1234);
      csr_rd(2'd2, 32'd0, "err_cnt_cleared");

      // Reset with reads in flight: the first retires before the reset edge,
      // the second is discarded
      csr_wr(2'd3, 32'd3);
      win_read = 1'b1; win_address = 4'd0;
      tick();
      win_address = 4'd1;
      tick();
      win_read = 1'b0; rst = 1'b1;
      check("rstmid_r1_valid", 64'(win_readdatavalid), 64'd1);
      check("rstmid_r1_data", win_readdata, pat(3, 0));
      tick();
      check("rstmid_no_valid", 64'(win_readdatavalid), 64'd0);
      check("rstmid_readdata", win_readdata, 64'd0);
      check("rstmid_wait", 64'(win_waitrequest), 64'd1);
      check("rstmid_csr", 64'(csr_readdata), 64'd0);
      tick();
      rst = 1'b0;
      check("rstmid_no_valid2", 64'(win_readdatavalid), 64'd0);
      check("rstmid_wait_hold", 64'(win_waitrequest), 64'd1);
      tick();
      check("rstmid_no_valid3", 64'(win_readdatavalid), 64'd0);
      check("rstmid_wait_drop", 64'(win_waitrequest), 64'd0);
      csr_rd(2'd3, 32'd0, "rstmid_page0");
      rd_check(4'd7, pat(0, 7), "rstmid_ram_p0");
      csr_wr(2'd3, 32'd3);
      rd_check(4'd1, pat(3, 1), "rstmid_ram_p3");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
